// File: rtl/sp_ram_access_ctrl.sv
// sp_ram_access_ctrl
// Arbitrates a write requester and a read requester onto one single-port RAM.
// Grants are combinational, alternate round-robin when both sides contend, and
// read data returns in request order through a 2-entry output buffer. Reads are
// only granted while the buffer plus the in-flight read can still absorb them,
// so the buffer can never overflow.
module sp_ram_access_ctrl #(
    parameter int ADR_WD = 7,
    parameter int DAT_WD = 64
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              wr_req_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_msk_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    output logic              wr_ack_o,

    input  logic              rd_req_i,
    input  logic [ADR_WD-1:0] rd_adr_i,
    output logic              rd_ack_o,
    output logic              rd_vld_o,
    output logic [DAT_WD-1:0] rd_dat_o,
    input  logic              rd_rdy_i,

    output logic [ADR_WD-1:0] ram_adr_o,
    output logic [DAT_WD-1:0] ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i
);

    // Round-robin pointer: 0 = write side first, 1 = read side first.
    logic              prio;

    // A read was granted last cycle; its RAM data is on ram_rd_dat_i now.
    logic              rd_inflight_p1;

    // Output buffer state.
    logic [DAT_WD-1:0] fifo_mem [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              fifo_push;
    logic              fifo_pop;
    logic [1:0]        rd_pending;
    logic              rd_elig;
    logic              wr_grant;
    logic              rd_grant;

    assign fifo_push = rd_inflight_p1;
    assign fifo_pop  = rd_vld_o && rd_rdy_i;

    assign rd_vld_o  = (fifo_cnt != 2'd0);
    assign rd_dat_o  = rd_vld_o ? fifo_mem[fifo_rd_ptr] : '0;

    assign wr_ack_o  = wr_grant;
    assign rd_ack_o  = rd_grant;

    // Read eligibility: buffered + in-flight reads, less the entry leaving
    // this cycle, must leave room for one more. At most 2 + 1 fits in 2 bits.
    always_comb begin
        rd_pending = fifo_cnt + {1'b0, rd_inflight_p1} - {1'b0, fifo_pop};
        rd_elig    = rd_req_i && (rd_pending < 2'd2);
    end

    // Grant selection: prio decides only when both sides are eligible.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (wr_req_i && rd_elig) begin
            if (prio) begin
                rd_grant = 1'b1;
            end else begin
                wr_grant = 1'b1;
            end
        end else if (wr_req_i) begin
            wr_grant = 1'b1;
        end else if (rd_elig) begin
            rd_grant = 1'b1;
        end
    end

    // RAM port drive, straight from the grant; idle parks everything at zero.
    always_comb begin
        ram_adr_o    = '0;
        ram_wr_ena_o = '0;
        ram_wr_dat_o = '0;
        ram_rd_ena_o = 1'b0;
        if (wr_grant) begin
            ram_adr_o    = wr_adr_i;
            ram_wr_ena_o = wr_msk_i;
            ram_wr_dat_o = wr_dat_i;
        end else if (rd_grant) begin
            ram_adr_o    = rd_adr_i;
            ram_rd_ena_o = 1'b1;
        end
    end

    // Priority flips to the side that did not just win.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= 1'b0;
        end else if (wr_grant) begin
            prio <= 1'b1;
        end else if (rd_grant) begin
            prio <= 1'b0;
        end
    end

    // Stage boundary p0 -> p1: remember a read grant until its data returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_inflight_p1 <= 1'b0;
        end else begin
            rd_inflight_p1 <= rd_grant;
        end
    end

    // Buffer pointers and occupancy; push and pop together leave count as is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Stage boundary p1 -> buffer: capture returning RAM data (data path, no reset).
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= ram_rd_dat_i;
        end
    end

`ifndef SYNTHESIS
    // The eligibility rule must make a push into a full buffer unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(fifo_push && !fifo_pop && (fifo_cnt == 2'd2)));

    // Never both grants in one cycle.
    a_one_grant: assert property (@(posedge clk) disable iff (!rstn)
        !(wr_grant && rd_grant));
`endif

endmodule

// File: tb/tb_sp_ram_access_ctrl.sv
// Testbench for sp_ram_access_ctrl: directed scenarios plus randomized traffic,
// checked by a scoreboard built on a behavioural RAM image and a queue of
// expected read returns.
module tb_sp_ram_access_ctrl;

    localparam int ADR_WD = 7;
    localparam int DAT_WD = 64;

    logic              clk;
    logic              rstn;
    logic              wr_req_i;
    logic [ADR_WD-1:0] wr_adr_i;
    logic [DAT_WD-1:0] wr_msk_i;
    logic [DAT_WD-1:0] wr_dat_i;
    logic              wr_ack_o;
    logic              rd_req_i;
    logic [ADR_WD-1:0] rd_adr_i;
    logic              rd_ack_o;
    logic              rd_vld_o;
    logic [DAT_WD-1:0] rd_dat_o;
    logic              rd_rdy_i;
    logic [ADR_WD-1:0] ram_adr_o;
    logic [DAT_WD-1:0] ram_wr_ena_o;
    logic [DAT_WD-1:0] ram_wr_dat_o;
    logic              ram_rd_ena_o;
    logic [DAT_WD-1:0] ram_rd_dat_i;

    sp_ram_access_ctrl #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_req_i     (wr_req_i),
        .wr_adr_i     (wr_adr_i),
        .wr_msk_i     (wr_msk_i),
        .wr_dat_i     (wr_dat_i),
        .wr_ack_o     (wr_ack_o),
        .rd_req_i     (rd_req_i),
        .rd_adr_i     (rd_adr_i),
        .rd_ack_o     (rd_ack_o),
        .rd_vld_o     (rd_vld_o),
        .rd_dat_o     (rd_dat_o),
        .rd_rdy_i     (rd_rdy_i),
        .ram_adr_o    (ram_adr_o),
        .ram_wr_ena_o (ram_wr_ena_o),
        .ram_wr_dat_o (ram_wr_dat_o),
        .ram_rd_ena_o (ram_rd_ena_o),
        .ram_rd_dat_i (ram_rd_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple registered-read RAM attached to the DUT's RAM port.
    logic [DAT_WD-1:0] ram_mem [128];
    always @(posedge clk) begin
        if (ram_rd_ena_o) ram_rd_dat_i <= ram_mem[ram_adr_o];
        ram_mem[ram_adr_o] <= (ram_mem[ram_adr_o] & ~ram_wr_ena_o) | (ram_wr_dat_o & ram_wr_ena_o);
    end

    // Scoreboard state.
    typedef struct {
        logic [DAT_WD-1:0] dat;
        int                ready;
    } exp_t;

    exp_t              exp_q [$];
    logic [DAT_WD-1:0] ref_mem [128];
    logic              exp_prio;
    int                cyc;
    int                n_checks;
    int                n_pass;
    logic              last_wr_ack;
    logic              last_rd_ack;
    int                rd_ack_cnt;
    int                vld_cnt;
    logic [DAT_WD-1:0] last_pop_dat;
    logic [2:0]        ghist [$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: predicts grants and read returns, compares every cycle at negedge.
    always @(negedge clk) begin
        logic exp_vld;
        logic pop_now;
        logic rd_ok;
        logic g_wr;
        logic g_rd;
        if (!rstn) begin
            check("rst_rd_vld", 128'(rd_vld_o), 128'(1'b0));
            check("rst_rd_dat", 128'(rd_dat_o), 128'(0));
            exp_q.delete();
            exp_prio    = 1'b0;
            last_wr_ack = 1'b0;
            last_rd_ack = 1'b0;
        end else begin
            exp_vld = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
            check("rd_vld", 128'(rd_vld_o), 128'(exp_vld));
            if (exp_vld) check("rd_dat", 128'(rd_dat_o), 128'(exp_q[0].dat));
            pop_now = exp_vld && rd_rdy_i;
            // Outstanding reads after this cycle's pop must be fewer than two.
            rd_ok   = rd_req_i && ((exp_q.size() - (pop_now ? 1 : 0)) < 2);
            if (wr_req_i && rd_ok) begin
                g_wr = !exp_prio;
                g_rd = exp_prio;
            end else begin
                g_wr = wr_req_i;
                g_rd = rd_ok;
            end
            check("wr_ack", 128'(wr_ack_o), 128'(g_wr));
            check("rd_ack", 128'(rd_ack_o), 128'(g_rd));
            if (g_wr) begin
                check("ram_wr_port", {ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o},
                      {wr_adr_i, wr_msk_i, wr_dat_i, 1'b0});
            end else if (g_rd) begin
                check("ram_rd_port", {ram_adr_o, ram_wr_ena_o, ram_rd_ena_o},
                      {rd_adr_i, 64'd0, 1'b1});
            end else begin
                check("ram_idle", {ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o}, 128'd0);
            end
            ghist.push_back({wr_ack_o, rd_ack_o, rd_vld_o});
            if (rd_ack_o) rd_ack_cnt++;
            if (rd_vld_o) vld_cnt++;
            if (rd_vld_o && rd_rdy_i) last_pop_dat = rd_dat_o;
            if (pop_now) void'(exp_q.pop_front());
            if (g_wr) begin
                ref_mem[wr_adr_i] = (ref_mem[wr_adr_i] & ~wr_msk_i) | (wr_dat_i & wr_msk_i);
                exp_prio = 1'b1;
            end
            if (g_rd) begin
                exp_q.push_back('{dat: ref_mem[rd_adr_i], ready: cyc + 2});
                exp_prio = 1'b0;
            end
            last_wr_ack = wr_ack_o;
            last_rd_ack = rd_ack_o;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        rstn     = 1'b0;
        tick();
        rstn     = 1'b1;
    endtask

    task automatic write_word(input logic [ADR_WD-1:0] adr, input logic [DAT_WD-1:0] msk,
                              input logic [DAT_WD-1:0] dat);
        wr_req_i = 1'b1;
        wr_adr_i = adr;
        wr_msk_i = msk;
        wr_dat_i = dat;
        tick();
        wr_req_i = 1'b0;
    endtask

    initial begin
        logic [11:0] am;
        logic [11:0] vm;
        int          r;

        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_rd_dat_i = '0;
        cyc = 0; n_checks = 0; n_pass = 0;
        exp_prio = 1'b0; last_wr_ack = 1'b0; last_rd_ack = 1'b0;
        rd_ack_cnt = 0; vld_cnt = 0; last_pop_dat = '0;
        rstn = 1'b0;
        wr_req_i = 1'b0; wr_adr_i = '0; wr_msk_i = '0; wr_dat_i = '0;
        rd_req_i = 1'b0; rd_adr_i = '0; rd_rdy_i = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Full write then read of the same word on the next cycle.
        ghist.delete();
        write_word(7'd5, {DAT_WD{1'b1}}, 64'h0123456789ABCDEF);
        rd_req_i = 1'b1; rd_adr_i = 7'd5;
        tick();
        rd_req_i = 1'b0;
        repeat (4) tick();
        check("wr_then_rd_wack_t0", 128'(ghist[0]), 128'(3'b100));
        check("wr_then_rd_rack_t1", 128'(ghist[1]), 128'(3'b010));
        check("wr_then_rd_vld_t2", 128'(ghist[2][0]), 128'(1'b0));
        check("wr_then_rd_vld_t3", 128'(ghist[3][0]), 128'(1'b1));
        check("wr_then_rd_data", 128'(last_pop_dat), 128'(64'h0123456789ABCDEF));

        // Masked write of the low half.
        write_word(7'd5, 64'h00000000FFFFFFFF, 64'd0);
        rd_req_i = 1'b1; rd_adr_i = 7'd5;
        tick();
        rd_req_i = 1'b0;
        repeat (4) tick();
        check("masked_wr_data", 128'(last_pop_dat), 128'(64'h0123456700000000));

        // Both sides requesting continuously from reset alternate W,R,W,R.
        pulse_reset();
        ghist.delete();
        wr_req_i = 1'b1; wr_adr_i = 7'd9; wr_msk_i = {DAT_WD{1'b1}}; wr_dat_i = 64'hDEADBEEF00C0FFEE;
        rd_req_i = 1'b1; rd_adr_i = 7'd5;
        repeat (4) tick();
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        repeat (5) tick();
        check("rr_g0", 128'(ghist[0][2:1]), 128'(2'b10));
        check("rr_g1", 128'(ghist[1][2:1]), 128'(2'b01));
        check("rr_g2", 128'(ghist[2][2:1]), 128'(2'b10));
        check("rr_g3", 128'(ghist[3][2:1]), 128'(2'b01));

        // Back-pressure: only two reads accepted while the consumer stalls.
        for (int i = 0; i < 8; i++) write_word(7'(16 + i), {DAT_WD{1'b1}}, {$urandom, $urandom});
        rd_rdy_i = 1'b0;
        rd_req_i = 1'b1; rd_adr_i = 7'd16;
        rd_ack_cnt = 0;
        repeat (6) begin
            tick();
            if (last_rd_ack) rd_adr_i = rd_adr_i + 7'd1;
        end
        check("stall_ack_count", 128'(rd_ack_cnt), 128'(2));
        rd_rdy_i = 1'b1;
        repeat (6) begin
            tick();
            if (last_rd_ack) rd_adr_i = rd_adr_i + 7'd1;
        end
        rd_req_i = 1'b0;
        repeat (5) tick();
        check("stall_total_acks", 128'(rd_ack_cnt > 2), 128'(1'b1));

        // Back-to-back reads of addresses 0..7 at full rate.
        for (int i = 0; i < 8; i++) write_word(7'(i), {DAT_WD{1'b1}}, {$urandom, $urandom});
        tick();
        ghist.delete();
        rd_ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd_req_i = 1'b1; rd_adr_i = 7'(i);
            tick();
        end
        rd_req_i = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 12; i++) begin
            am[i] = ghist[i][1];
            vm[i] = ghist[i][0];
        end
        check("stream_ack_mask", 128'(am), 128'(12'h0FF));
        check("stream_vld_mask", 128'(vm), 128'(12'h3FC));
        check("stream_ack_count", 128'(rd_ack_cnt), 128'(8));

        // Reset one cycle after a read grant drops the in-flight read.
        rd_req_i = 1'b1; rd_adr_i = 7'd3;
        tick();
        rd_req_i = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        vld_cnt = 0;
        repeat (5) tick();
        check("rst_flush_no_vld", 128'(vld_cnt), 128'(0));
        ghist.delete();
        rd_req_i = 1'b1; rd_adr_i = 7'd3;
        tick();
        rd_req_i = 1'b0;
        repeat (3) tick();
        check("post_rst_rack", 128'(ghist[0][1]), 128'(1'b1));
        for (int i = 0; i < 4; i++) vm[i] = ghist[i][0];
        check("post_rst_latency", 128'(vm[3:0]), 128'(4'b0100));

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                pulse_reset();
            end else begin
                if (!wr_req_i || last_wr_ack) begin
                    wr_req_i = ($urandom_range(0, 99) < 45);
                    wr_adr_i = 7'($urandom_range(0, 15));
                    r = $urandom_range(0, 3);
                    wr_msk_i = (r == 0) ? {DAT_WD{1'b1}} : (r == 1) ? '0 : {$urandom, $urandom};
                    wr_dat_i = {$urandom, $urandom};
                end
                if (!rd_req_i || last_rd_ack) begin
                    rd_req_i = ($urandom_range(0, 99) < 60);
                    rd_adr_i = 7'($urandom_range(0, 15));
                end
                rd_rdy_i = ($urandom_range(0, 99) < 70);
                tick();
            end
        end
        wr_req_i = 1'b0; rd_req_i = 1'b0; rd_rdy_i = 1'b1;
        repeat (8) tick();
        check("drain_no_vld", 128'(rd_vld_o), 128'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d required 0 stalled cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sp_ram_access_ctrl.md
SP_RAM_ACCESS_CTRL -- requirements
Module: sp_ram_access_ctrl

Interface
REQ-001 Parameter ADR_WD, default 7, RAM address width (128 words).
REQ-002 Parameter DAT_WD, default 64, RAM data and bit-enable width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 wr_req_i  input  1  write request, held until wr_ack_o.
REQ-006 wr_adr_i  input  ADR_WD  write word address.
REQ-007 wr_msk_i  input  DAT_WD  per-bit write enable, high active.
REQ-008 wr_dat_i  input  DAT_WD  write data.
REQ-009 wr_ack_o  output  1  write accepted this cycle (combinational grant).
REQ-010 rd_req_i  input  1  read request, held until rd_ack_o.
REQ-011 rd_adr_i  input  ADR_WD  read word address.
REQ-012 rd_ack_o  output  1  read accepted this cycle (combinational grant).
REQ-013 rd_vld_o  output  1  read data valid (head of output buffer).
REQ-014 rd_dat_o  output  DAT_WD  read data, returned in request order.
REQ-015 rd_rdy_i  input  1  consumer ready; pop when rd_vld_o && rd_rdy_i.
REQ-016 ram_adr_o  output  ADR_WD  RAM address.
REQ-017 ram_wr_ena_o  output  DAT_WD  RAM per-bit write enable, high active.
REQ-018 ram_wr_dat_o  output  DAT_WD  RAM write data.
REQ-019 ram_rd_ena_o  output  1  RAM read strobe, high active.
REQ-020 ram_rd_dat_i  input  DAT_WD  RAM read data, valid the cycle after ram_rd_ena_o.

Function
REQ-021 Per cycle exactly one of: write grant, read grant, idle; RAM port outputs are combinational from the grant.
REQ-022 Write grant: ram_wr_ena_o=wr_msk_i, ram_wr_dat_o=wr_dat_i, ram_adr_o=wr_adr_i, ram_rd_ena_o=0, wr_ack_o=1.
REQ-023 Read grant: ram_rd_ena_o=1, ram_adr_o=rd_adr_i, ram_wr_ena_o=0, rd_ack_o=1.
REQ-024 Idle: ram_rd_ena_o=0, ram_wr_ena_o=0, ram_adr_o=0, ram_wr_dat_o=0.
REQ-025 Write grant with wr_msk_i=0 still counts as grant (acked, no RAM bits written).
REQ-026 Read is eligible only if (buffer occupancy + in-flight reads) < 2 counting this cycle's pop; write eligibility has no condition.
REQ-027 Arbitration round-robin: 1-bit priority flag prio (0=write first, 1=read first); when both eligible, prioritized side wins; after any grant prio points to the other side.
REQ-028 A lone eligible requester is granted regardless of prio.
REQ-029 Read latency: grant at cycle T, ram_rd_dat_i sampled at end of T+1 into 2-entry FIFO, rd_vld_o=1 earliest at T+2.
REQ-030 rd_dat_o is head entry; holds stable while rd_vld_o=1 and rd_rdy_i=0.
REQ-031 Simultaneous push and pop with occupancy 1 or 2: occupancy unchanged, order preserved.
REQ-032 FIFO never overflows; push into a full FIFO is impossible by REQ-026 and is an assertion failure.
REQ-033 Write at T then read of same address at T+1 returns the written data (RAM ordering, no bypass).
REQ-034 Sustained throughput with rd_rdy_i=1: one read per cycle when only reads request.

Reset
REQ-035 While rstn=0: prio=0, FIFO occupancy 0, in-flight flag 0, rd_vld_o=0, rd_dat_o=0.
REQ-036 Reset asserted mid-operation discards in-flight reads and buffered data; no rd_vld_o pulse after deassertion without a new grant.
REQ-037 With rstn=0, acks and RAM strobes follow REQ-021..REQ-028 combinationally but no state updates; benches keep requests low during reset.

Verification
REQ-038 Write adr=5, msk=all-ones, dat=0x0123456789ABCDEF; then read adr=5 -> wr_ack at T, rd_ack at T+1, rd_vld_o=1 at T+3 with rd_dat_o=0x0123456789ABCDEF.
REQ-039 Partial write adr=5 msk=0x00000000FFFFFFFF dat=0 over previous value; read -> 0x0123456700000000.
REQ-040 Both requests held high for 4 cycles from reset -> grants W,R,W,R.
REQ-041 rd_rdy_i=0, rd_req_i held high -> exactly 2 rd_ack_o pulses, then rd_ack_o=0 until rd_rdy_i=1; after release data returns in address order, none lost.
REQ-042 Reads to adr 0..7 back-to-back, rd_rdy_i=1 -> rd_ack_o high 8 consecutive cycles, rd_vld_o high 8 consecutive cycles starting 2 cycles later.
REQ-043 rstn pulsed low 1 cycle after read grant -> rd_vld_o stays 0; next read completes normally with latency 2.
